mem_io_responder: RTL and testbench

Byte-wide memory/IO responder sitting on the far side of the CPU's `mem_a`/`mem_din`/`mem_dout`/`mem_wr` bus, opposite the `memory_controller` initiator. It stores the 128 KB program/data RAM, decodes the IO window at `mem_a[17:16]==2'b11`, buffers UART output bytes in a small FIFO, sources UART input bytes and the cycle counter, and raises `io_buffer_full` and `program_stop`. It replaces the behavioural RAM/HCI model used in simulation and is the synthesizable endpoint on FPGA.

---
 rtl/mem_io_responder_pkg.sv | 30 +++
 rtl/mem_io_responder_if.sv | 35 +++
 rtl/mem_io_responder_byte_fifo.sv | 69 ++++++
 rtl/mem_io_responder.sv | 138 +++++++++++++
 tb/tb_mem_io_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and IO-window decode for the memory/IO responder.
package mem_io_pkg;

  localparam int                    MEM_ADDR_W   = 18;
  localparam logic [1:0]            IO_SEL       = 2'b11;
  localparam logic [MEM_ADDR_W-1:0] IO_UART_ADDR = 18'h30000;
  localparam logic [MEM_ADDR_W-1:0] IO_CLK_ADDR  = 18'h30004;

  // Register selected inside the IO window.
  typedef enum logic [1:0] {
    IO_UART = 2'd0,  // 0x30000: TX write / RX read
    IO_CLK  = 2'd1,  // 0x30004: stop write / counter byte 0 + snapshot
    IO_SNAP = 2'd2,  // 0x30005..0x30007: snapshot bytes 1..3
    IO_NONE = 2'd3   // anything else in the window
  } io_reg_e;

  // Classify an 18-bit address within the IO window.
  function automatic io_reg_e io_decode(input logic [MEM_ADDR_W-1:0] a);
    if (a == IO_UART_ADDR) begin
      return IO_UART;
    end else if (a == IO_CLK_ADDR) begin
      return IO_CLK;
    end else if (a[MEM_ADDR_W-1:2] == IO_CLK_ADDR[MEM_ADDR_W-1:2]) begin
      return IO_SNAP;
    end else begin
      return IO_NONE;
    end
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART byte streams between the CPU side and the responder.
//
// Handshakes:
//   tx: a byte moves on every cycle where tx_valid && tx_ready are both high;
//       tx_data is stable while tx_valid is high and tx_ready is low.
//   rx: rx_valid marks an unread rx_data; rx_pop is a one-cycle pulse that
//       consumes it and is only raised while rx_valid is high.
//   cpu: no handshake; every cycle is a read (mem_wr=0) or a write (mem_wr=1).
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;
  logic        tx_overflow;

  modport master (
    output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop,
           program_stop, tx_overflow
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop,
           program_stop, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Registered byte FIFO; rdata shows the head byte and reads 0 while empty.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]    CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]    CNT_MAX = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_MAX);
  assign count = count_q;
  assign rdata = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A push into a full FIFO only lands when the head leaves the same cycle;
  // at full wr_ptr==rd_ptr, so the new byte simply reuses the departing slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointer and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset drops any queued bytes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage, not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Far-side endpoint of the CPU byte bus: program/data RAM, UART TX FIFO,
// UART RX source, free-running cycle counter and the stop flag.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 8
) (
  input logic               clk,
  input logic               rst,
  mem_io_responder_if.slave bus
);

  localparam int            CW       = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(TX_DEPTH - 1);
  localparam int            RAM_BYTES = 1 << RAM_ADDR_WIDTH;

  logic [MEM_ADDR_W-1:0]     addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      unused_addr_hi;
  logic                      io_sel, ram_we, ram_rd, io_rd, io_wr;
  io_reg_e                   io_reg;

  logic [7:0]    ram_mem [RAM_BYTES];
  logic [7:0]    ram_rdata_q;
  logic [31:0]   counter_q;
  logic [31:0]   snapshot_q, snapshot_d;
  logic [7:0]    io_rdata_q, io_rdata_d;
  logic          rd_sel_io_q, rd_sel_io_d;
  logic          program_stop_q, program_stop_d;
  logic          tx_overflow_q, tx_overflow_d;

  logic          tx_push, tx_pop, tx_empty, tx_full, stop_set;
  logic [7:0]    tx_wdata, tx_rdata;
  logic [CW-1:0] tx_count;

  assign addr           = bus.mem_a[MEM_ADDR_W-1:0];
  assign unused_addr_hi = ^bus.mem_a[31:MEM_ADDR_W];
  assign ram_addr       = addr[RAM_ADDR_WIDTH-1:0];
  assign io_sel         = (addr[MEM_ADDR_W-1 -: 2] == IO_SEL);
  assign io_reg         = io_decode(addr);
  assign ram_we         = bus.mem_wr && !io_sel;
  assign ram_rd         = !bus.mem_wr && !io_sel;
  assign io_wr          = bus.mem_wr && io_sel;
  assign io_rd          = !bus.mem_wr && io_sel;

  // RX byte is consumed in the same cycle as the read that returns it.
  assign bus.rx_pop = io_rd && (io_reg == IO_UART) && bus.rx_valid;

  // IO writes: UART byte (zero is dropped) or stop marker (always 0x00).
  always_comb begin
    tx_push  = 1'b0;
    tx_wdata = bus.mem_dout;
    stop_set = 1'b0;
    if (io_wr) begin
      case (io_reg)
        IO_UART: tx_push = (bus.mem_dout != 8'h00);
        IO_CLK: begin
          tx_push  = 1'b1;
          tx_wdata = 8'h00;
          stop_set = 1'b1;
        end
        default: tx_push = 1'b0;
      endcase
    end
  end

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .count (tx_count),
    .empty (tx_empty),
    .full  (tx_full)
  );

  assign tx_pop             = bus.tx_ready && !tx_empty;
  assign bus.tx_valid       = !tx_empty;
  assign bus.tx_data        = tx_rdata;
  // One slot of slack is kept for a write already in flight from the CPU.
  assign bus.io_buffer_full = (tx_count >= FULL_LVL);

  // IO read data, snapshot capture, read-source select and sticky flags.
  always_comb begin
    io_rdata_d     = io_rdata_q;
    snapshot_d     = snapshot_q;
    rd_sel_io_d    = rd_sel_io_q;
    program_stop_d = program_stop_q | stop_set;
    tx_overflow_d  = tx_overflow_q | (tx_push & tx_full & ~tx_pop);
    if (io_rd) begin
      rd_sel_io_d = 1'b1;
      case (io_reg)
        IO_UART: io_rdata_d = bus.rx_valid ? bus.rx_data : 8'h00;
        IO_CLK: begin
          io_rdata_d = counter_q[7:0];
          snapshot_d = counter_q;
        end
        IO_SNAP: io_rdata_d = snapshot_q[{addr[1:0], 3'b000} +: 8];
        default: io_rdata_d = 8'h00;
      endcase
    end else if (ram_rd) begin
      rd_sel_io_d = 1'b0;
    end
  end

  // Control registers; the read select resets to IO so mem_din starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_q      <= 32'd0;
      snapshot_q     <= 32'd0;
      io_rdata_q     <= 8'h00;
      rd_sel_io_q    <= 1'b1;
      program_stop_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      counter_q      <= counter_q + 32'd1;
      snapshot_q     <= snapshot_d;
      io_rdata_q     <= io_rdata_d;
      rd_sel_io_q    <= rd_sel_io_d;
      program_stop_q <= program_stop_d;
      tx_overflow_q  <= tx_overflow_d;
    end
  end

  // Single-port RAM with registered read; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= bus.mem_dout;
    if (ram_rd) ram_rdata_q <= ram_mem[ram_addr];
  end

  assign bus.mem_din      = rd_sel_io_q ? io_rdata_q : ram_rdata_q;
  assign bus.program_stop = program_stop_q;
  assign bus.tx_overflow  = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder.
module tb_mem_io_responder;

  logic clk = 1'b0;
  logic rst;

  mem_io_responder_if bus ();

  mem_io_responder #(.RAM_ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  int         total = 0;
  int         bad = 0;
  int         extra_pops = 0;
  logic [7:0] exp_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // TX monitor: a byte leaves on a clock where tx_valid && tx_ready.
  always @(negedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check("tx_data", {24'h0, bus.tx_data}, {24'h0, exp_b});
      end else begin
        extra_pops++;
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic idle();
    @(posedge clk); #1;
    bus.mem_a = 32'h0; bus.mem_wr = 1'b0; bus.mem_dout = 8'h00;
  endtask

  task automatic write(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.mem_a = a; bus.mem_wr = 1'b1; bus.mem_dout = d;
  endtask

  task automatic tx_write(input logic [7:0] d, input bit accept);
    write(32'h0003_0000, d);
    if (accept && d != 8'h00) exp_q.push_back(d);
  endtask

  task automatic read(input logic [31:0] a, input logic [7:0] e, input logic pop_e);
    @(posedge clk); #1;
    bus.mem_a = a; bus.mem_wr = 1'b0; bus.mem_dout = 8'h00;
    rd_q.push_back(e);
    #1 check("rx_pop", {31'h0, bus.rx_pop}, {31'h0, pop_e});
    @(posedge clk); #1;
    check("mem_din", {24'h0, bus.mem_din}, {24'h0, rd_q.pop_front()});
    bus.mem_a = 32'h0; bus.mem_wr = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    repeat (14) idle();
    check(tag, exp_q.size(), 0);
    check("tx_extra", extra_pops, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    bus.tx_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_a = 32'h0; bus.mem_wr = 1'b0; bus.mem_dout = 8'h00;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

    // Reset values
    #12;
    check("rst_mem_din",   {24'h0, bus.mem_din}, 0);
    check("rst_tx_valid",  {31'h0, bus.tx_valid}, 0);
    check("rst_tx_data",   {24'h0, bus.tx_data}, 0);
    check("rst_buf_full",  {31'h0, bus.io_buffer_full}, 0);
    check("rst_rx_pop",    {31'h0, bus.rx_pop}, 0);
    check("rst_stop",      {31'h0, bus.program_stop}, 0);
    check("rst_overflow",  {31'h0, bus.tx_overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    // RAM round trip, hold across writes, read-after-write
    write(32'h0000_0100, 8'hAB);
    @(posedge clk); #1;
    bus.mem_a = 32'h0000_0100; bus.mem_wr = 1'b0;
    write(32'h0000_0200, 8'h11);
    check("ram_rd", {24'h0, bus.mem_din}, 32'hAB);
    write(32'h0000_0201, 8'h22);
    check("ram_hold", {24'h0, bus.mem_din}, 32'hAB);
    write(32'h0000_0101, 8'hCD);
    read(32'h0000_0200, 8'h11, 1'b0);
    read(32'h0000_0100, 8'hAB, 1'b0);
    read(32'h0000_0101, 8'hCD, 1'b0);
    write(32'h0000_0300, 8'h3C);
    read(32'h0000_0300, 8'h3C, 1'b0);

    // UART TX ordering with zero suppression
    bus.tx_ready = 1'b1;
    tx_write(8'h48, 1'b1);
    tx_write(8'h00, 1'b1);
    tx_write(8'h69, 1'b1);
    write(32'h0003_0008, 8'h55);   // unmapped IO write is ignored
    drain_check("tx_order_drain");

    // Backpressure and overflow
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tx_write(8'h10 + 8'(i), i <= 8);
      check("buf_full", {31'h0, bus.io_buffer_full}, {31'h0, (i - 1) >= 7});
    end
    check("ovf_pre", {31'h0, bus.tx_overflow}, 0);
    idle();
    check("ovf_set",   {31'h0, bus.tx_overflow}, 1);
    check("full_hold", {31'h0, bus.io_buffer_full}, 1);
    bus.tx_ready = 1'b1;
    drain_check("bp_drain");
    check("full_clr", {31'h0, bus.io_buffer_full}, 0);

    // Program stop
    tx_write(8'h00, 1'b0);
    write(32'h0003_0004, 8'h7F);
    exp_q.push_back(8'h00);
    check("stop_pre", {31'h0, bus.program_stop}, 0);
    idle();
    check("stop_set", {31'h0, bus.program_stop}, 1);
    drain_check("stop_drain");

    // RX reads and unmapped IO read
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    read(32'h0003_0000, 8'h5A, 1'b1);
    bus.rx_valid = 1'b0; bus.rx_data = 8'hC3;
    read(32'h0003_0000, 8'h00, 1'b0);
    bus.rx_valid = 1'b1;
    read(32'h0003_0010, 8'h00, 1'b0);
    bus.rx_valid = 1'b0;

    // Reset mid-operation with 3 bytes queued
    bus.tx_ready = 1'b0;
    tx_write(8'hA1, 1'b1);
    tx_write(8'hA2, 1'b1);
    tx_write(8'hA3, 1'b1);
    idle();
    check("pre_rst_valid", {31'h0, bus.tx_valid}, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_tx_valid", {31'h0, bus.tx_valid}, 0);
    check("arst_stop",     {31'h0, bus.program_stop}, 0);
    check("arst_ovf",      {31'h0, bus.tx_overflow}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Push and pop together while full
    for (int i = 0; i < 8; i++) tx_write(8'hB0 + 8'(i), 1'b1);
    idle();
    check("pp_full", {31'h0, bus.io_buffer_full}, 1);
    tx_write(8'hEE, 1'b1);
    bus.tx_ready = 1'b1;
    drain_check("pp_drain");
    check("pp_no_ovf", {31'h0, bus.tx_overflow}, 0);

    // Counter snapshot
    do_reset();
    repeat (99) @(posedge clk);
    read(32'h0003_0004, 8'h64, 1'b0);          // cycle 100
    repeat (8) @(posedge clk);
    read(32'h0003_0005, 8'h00, 1'b0);          // cycle 110
    read(32'h0003_0006, 8'h00, 1'b0);
    read(32'h0003_0007, 8'h00, 1'b0);
    repeat (134) @(posedge clk);
    read(32'h0003_0004, 8'hFA, 1'b0);          // cycle 250
    repeat (8) @(posedge clk);
    read(32'h0003_0005, 8'h00, 1'b0);          // snapshot, not live 0x104
    repeat (38) @(posedge clk);
    read(32'h0003_0004, 8'h2C, 1'b0);          // cycle 300 = 0x12C
    read(32'h0003_0005, 8'h01, 1'b0);

    check("final_q", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
